// File: rtl/mips_ctrl.sv
// -----------------------------------------------------------------------------
// mips_ctrl
//   Multi-cycle MIPS control unit. A Moore/Mealy FSM that sequences fetch,
//   decode, execute, memory and write-back steps and drives the datapath
//   control lines. All outputs are combinational from the current state, the
//   instruction fields (opcode/funct) and mem_ready, and are forced to 0 while
//   rst_n is low.
//
//   Parameters
//     HALT_OPCODE    opcode that parks the FSM in HALT until reset
//   Ports
//     clk            rising-edge clock
//     rst_n          asynchronous active-low reset (state -> FETCH)
//     opcode         IR[31:26]
//     funct          IR[5:0]
//     mem_ready      memory completes the current access this cycle
//     pc_write .. alu_src_a   single-bit datapath controls
//     alu_src_b      00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2
//     pc_source      00 ALU result, 01 ALUOut reg, 10 jump target
//     alu_lo_hi      00 ALUOut, 01 LO, 10 HI
//     hi_en, lo_en   HI/LO register load enables
//     opsel          ALU operation select
//     illegal_op     one-cycle pulse on unsupported opcode/funct
// -----------------------------------------------------------------------------
module mips_ctrl #(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       jal,
    output logic       is_signed,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_lo_hi,
    output logic       hi_en,
    output logic       lo_en,
    output logic [4:0] opsel,
    output logic       illegal_op
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_RTYPE_EX  = 4'd6;
    localparam logic [3:0] S_RTYPE_WB  = 4'd7;
    localparam logic [3:0] S_ITYPE_EX  = 4'd8;
    localparam logic [3:0] S_ITYPE_WB  = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_JAL       = 4'd12;
    localparam logic [3:0] S_HALT      = 4'd13;

    localparam logic [4:0] OP_ADD_U  = 5'h00;
    localparam logic [4:0] OP_SUB_U  = 5'h01;
    localparam logic [4:0] OP_MULT   = 5'h02;
    localparam logic [4:0] OP_MUL_U  = 5'h03;
    localparam logic [4:0] OP_AND    = 5'h04;
    localparam logic [4:0] OP_OR     = 5'h05;
    localparam logic [4:0] OP_XOR    = 5'h06;
    localparam logic [4:0] OP_SRL    = 5'h07;
    localparam logic [4:0] OP_SLL    = 5'h08;
    localparam logic [4:0] OP_SRA    = 5'h09;
    localparam logic [4:0] OP_SLT    = 5'h0A;
    localparam logic [4:0] OP_SLT_U  = 5'h0B;
    localparam logic [4:0] OP_BEQ    = 5'h0C;
    localparam logic [4:0] OP_BNE    = 5'h0D;
    localparam logic [4:0] OP_PASS_A = 5'h10;

    logic [3:0] r_state;
    logic [3:0] w_next;

    // R-type funct decode
    logic [4:0] w_rt_opsel;
    logic       w_rt_valid;
    logic       w_rt_mult;
    logic       w_rt_jr;
    logic       w_rt_mfhi;
    logic       w_rt_mflo;

    // I-type opcode decode
    logic [4:0] w_it_opsel;
    logic       w_it_signed;
    logic       w_it_valid;

    // unmasked control outputs
    logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_jal;
    logic       w_is_signed, w_alu_src_a, w_hi_en, w_lo_en, w_illegal_op;
    logic [1:0] w_alu_src_b, w_pc_source, w_alu_lo_hi;
    logic [4:0] w_opsel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_rt_opsel = OP_ADD_U;
        w_rt_valid = 1'b1;
        w_rt_mult  = 1'b0;
        w_rt_jr    = 1'b0;
        w_rt_mfhi  = 1'b0;
        w_rt_mflo  = 1'b0;
        case (funct)
            6'h21: w_rt_opsel = OP_ADD_U;
            6'h23: w_rt_opsel = OP_SUB_U;
            6'h18: begin w_rt_opsel = OP_MULT;  w_rt_mult = 1'b1; end
            6'h19: begin w_rt_opsel = OP_MUL_U; w_rt_mult = 1'b1; end
            6'h24: w_rt_opsel = OP_AND;
            6'h25: w_rt_opsel = OP_OR;
            6'h26: w_rt_opsel = OP_XOR;
            6'h02: w_rt_opsel = OP_SRL;
            6'h00: w_rt_opsel = OP_SLL;
            6'h03: w_rt_opsel = OP_SRA;
            6'h2A: w_rt_opsel = OP_SLT;
            6'h2B: w_rt_opsel = OP_SLT_U;
            6'h08: begin w_rt_opsel = OP_PASS_A; w_rt_jr = 1'b1; end
            6'h10: w_rt_mfhi = 1'b1;
            6'h12: w_rt_mflo = 1'b1;
            default: w_rt_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_it_opsel  = OP_ADD_U;
        w_it_signed = 1'b0;
        w_it_valid  = 1'b1;
        case (opcode)
            6'h09: begin w_it_opsel = OP_ADD_U;  w_it_signed = 1'b1; end
            6'h10: begin w_it_opsel = OP_SUB_U;  w_it_signed = 1'b1; end
            6'h0A: begin w_it_opsel = OP_SLT;    w_it_signed = 1'b1; end
            6'h0B: begin w_it_opsel = OP_SLT_U;  w_it_signed = 1'b1; end
            6'h0C: w_it_opsel = OP_AND;
            6'h0D: w_it_opsel = OP_OR;
            6'h0E: w_it_opsel = OP_XOR;
            default: w_it_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_next          = r_state;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_jal           = 1'b0;
        w_is_signed     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_pc_source     = 2'b00;
        w_alu_lo_hi     = 2'b00;
        w_hi_en         = 1'b0;
        w_lo_en         = 1'b0;
        w_opsel         = OP_ADD_U;
        w_illegal_op    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                // IR and PC+4 commit only in the cycle the read completes
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // speculative branch target: PC + (sext(imm) << 2)
                w_alu_src_b = 2'b11;
                w_is_signed = 1'b1;
                if (opcode == 6'h00)                           w_next = S_RTYPE_EX;
                else if (opcode == 6'h23 || opcode == 6'h2B)   w_next = S_MEM_ADDR;
                else if (w_it_valid)                           w_next = S_ITYPE_EX;
                else if (opcode == 6'h04 || opcode == 6'h05)   w_next = S_BRANCH;
                else if (opcode == 6'h02)                      w_next = S_JUMP;
                else if (opcode == 6'h03)                      w_next = S_JAL;
                else if (opcode == HALT_OPCODE)                w_next = S_HALT;
                else begin
                    w_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_is_signed = 1'b1;
                w_next      = (opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                w_i_or_d   = 1'b1;
                w_mem_read = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_i_or_d    = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_RTYPE_EX: begin
                w_alu_src_a = 1'b1;
                w_opsel     = w_rt_opsel;
                if (!w_rt_valid) begin
                    w_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end else if (w_rt_mult) begin
                    w_hi_en = 1'b1;
                    w_lo_en = 1'b1;
                    w_next  = S_FETCH;
                end else if (w_rt_jr) begin
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_RTYPE_WB;
                end
            end
            S_RTYPE_WB: begin
                // funct is still held in IR, so the EX opsel is regenerated
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_opsel     = w_rt_opsel;
                if (w_rt_mfhi)      w_alu_lo_hi = 2'b10;
                else if (w_rt_mflo) w_alu_lo_hi = 2'b01;
                w_next = S_FETCH;
            end
            S_ITYPE_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_opsel     = w_it_opsel;
                w_is_signed = w_it_signed;
                w_next      = S_ITYPE_WB;
            end
            S_ITYPE_WB: begin
                w_reg_write = 1'b1;
                w_opsel     = w_it_opsel;
                w_is_signed = w_it_signed;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_opsel         = (opcode == 6'h05) ? OP_BNE : OP_BEQ;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_jal       = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Every control line is held low while reset is asserted
    assign pc_write      = rst_n & w_pc_write;
    assign pc_write_cond = rst_n & w_pc_write_cond;
    assign i_or_d        = rst_n & w_i_or_d;
    assign mem_read      = rst_n & w_mem_read;
    assign mem_write     = rst_n & w_mem_write;
    assign ir_write      = rst_n & w_ir_write;
    assign mem_to_reg    = rst_n & w_mem_to_reg;
    assign reg_dst       = rst_n & w_reg_dst;
    assign reg_write     = rst_n & w_reg_write;
    assign jal           = rst_n & w_jal;
    assign is_signed     = rst_n & w_is_signed;
    assign alu_src_a     = rst_n & w_alu_src_a;
    assign hi_en         = rst_n & w_hi_en;
    assign lo_en         = rst_n & w_lo_en;
    assign illegal_op    = rst_n & w_illegal_op;
    assign alu_src_b     = rst_n ? w_alu_src_b : 2'b00;
    assign pc_source     = rst_n ? w_pc_source : 2'b00;
    assign alu_lo_hi     = rst_n ? w_alu_lo_hi : 2'b00;
    assign opsel         = rst_n ? w_opsel     : 5'h00;

endmodule

// File: tb/tb_mips_ctrl.sv
module tb_mips_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, jal, is_signed, alu_src_a;
    logic [1:0] alu_src_b, pc_source, alu_lo_hi;
    logic       hi_en, lo_en, illegal_op;
    logic [4:0] opsel;

    mips_ctrl #(.HALT_OPCODE(6'h3F)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .jal(jal),
        .is_signed(is_signed), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_lo_hi(alu_lo_hi), .hi_en(hi_en), .lo_en(lo_en),
        .opsel(opsel), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, jal, is_signed, alu_src_a;
        logic [1:0] alu_src_b, pc_source, alu_lo_hi;
        logic       hi_en, lo_en;
        logic [4:0] opsel;
        logic       illegal_op;
    } ctl_t;

    // One step of an instruction's micro-sequence
    typedef struct {
        ctl_t base;
        ctl_t rdy_add;   // extra controls asserted when mem_ready=1 in a wait step
        bit   waits;     // step repeats until mem_ready
        bit   sticky;    // step never ends (halt)
        bit   fetch;
    } step_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    ctl_t  dut_v;
    assign dut_v = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, jal, is_signed, alu_src_a,
                    alu_src_b, pc_source, alu_lo_hi, hi_en, lo_en, opsel, illegal_op};

    step_t q_steps[$];
    step_t m_cur;
    int    m_stepno = 0;
    lit_t  lit_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    done = 0;

    int st_cycles, st_mrd, st_memwb, st_rdwb, st_rw, st_hilo, st_ill;
    logic [4:0] st_mul_opsel, st_it_opsel;
    logic [1:0] st_lohi;
    logic       st_it_signed;

    function automatic step_t mk(input ctl_t b);
        step_t s;
        s.base = b; s.rdy_add = '0; s.waits = 0; s.sticky = 0; s.fetch = 0;
        return s;
    endfunction

    function automatic step_t fetch_step();
        ctl_t  b;
        step_t s;
        b = '0; b.mem_read = 1'b1; b.alu_src_b = 2'b01;
        s = mk(b);
        s.waits = 1; s.fetch = 1;
        s.rdy_add.ir_write = 1'b1; s.rdy_add.pc_write = 1'b1;
        return s;
    endfunction

    // ALU op for an R-type funct; -1 marks an unsupported funct
    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'h21: return 'h00;  6'h23: return 'h01;  6'h18: return 'h02;
            6'h19: return 'h03;  6'h24: return 'h04;  6'h25: return 'h05;
            6'h26: return 'h06;  6'h02: return 'h07;  6'h00: return 'h08;
            6'h03: return 'h09;  6'h2A: return 'h0A;  6'h2B: return 'h0B;
            6'h08: return 'h10;  6'h10: return 'h00;  6'h12: return 'h00;
            default: return -1;
        endcase
    endfunction

    // ALU op for an I-type opcode; -1 if not an immediate ALU op
    function automatic int i_alu(input logic [5:0] op);
        case (op)
            6'h09: return 'h00;  6'h10: return 'h01;  6'h0C: return 'h04;
            6'h0D: return 'h05;  6'h0E: return 'h06;  6'h0A: return 'h0A;
            6'h0B: return 'h0B;
            default: return -1;
        endcase
    endfunction

    task automatic push_wait(input ctl_t c);
        step_t s;
        s = mk(c); s.waits = 1;
        q_steps.push_back(s);
    endtask

    // Queue the post-fetch micro-steps of one instruction
    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        step_t s;
        int r, it;
        bit known;
        it = i_alu(op);
        known = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (it >= 0) ||
                (op == 6'h04) || (op == 6'h05) || (op == 6'h02) || (op == 6'h03) ||
                (op == 6'h3F);
        c = '0; c.alu_src_b = 2'b11; c.is_signed = 1'b1;
        c.illegal_op = !known;
        q_steps.push_back(mk(c));
        if (op == 6'h00) begin
            r = r_alu(fn);
            c = '0; c.alu_src_a = 1'b1;
            if (r < 0) begin
                c.illegal_op = 1'b1;
                q_steps.push_back(mk(c));
            end else begin
                c.opsel = 5'(r);
                if (fn == 6'h18 || fn == 6'h19) begin
                    c.hi_en = 1'b1; c.lo_en = 1'b1;
                    q_steps.push_back(mk(c));
                end else if (fn == 6'h08) begin
                    c.pc_write = 1'b1;
                    q_steps.push_back(mk(c));
                end else begin
                    q_steps.push_back(mk(c));
                    c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1; c.opsel = 5'(r);
                    c.alu_lo_hi = (fn == 6'h10) ? 2'b10 : (fn == 6'h12) ? 2'b01 : 2'b00;
                    q_steps.push_back(mk(c));
                end
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.is_signed = 1'b1;
            q_steps.push_back(mk(c));
            c = '0; c.i_or_d = 1'b1;
            if (op == 6'h23) begin
                c.mem_read = 1'b1; push_wait(c);
                c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                q_steps.push_back(mk(c));
            end else begin
                c.mem_write = 1'b1; push_wait(c);
            end
        end else if (it >= 0) begin
            c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.opsel = 5'(it);
            c.is_signed = (op == 6'h09 || op == 6'h10 || op == 6'h0A || op == 6'h0B);
            q_steps.push_back(mk(c));
            c.alu_src_a = 1'b0; c.alu_src_b = 2'b00; c.reg_write = 1'b1;
            q_steps.push_back(mk(c));
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.alu_src_a = 1'b1; c.opsel = (op == 6'h05) ? 5'h0D : 5'h0C;
            c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            q_steps.push_back(mk(c));
        end else if (op == 6'h02 || op == 6'h03) begin
            c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10;
            c.jal = (op == 6'h03); c.reg_write = (op == 6'h03);
            q_steps.push_back(mk(c));
        end else if (op == 6'h3F) begin
            s = mk('0); s.sticky = 1;
            q_steps.push_back(s);
        end
    endtask

    function automatic ctl_t expected();
        ctl_t e;
        if (!rst_n) return '0;
        e = m_cur.base;
        if (m_cur.waits && mem_ready) e = e | m_cur.rdy_add;
        return e;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_cur = fetch_step(); q_steps.delete(); m_stepno++;
        end else if (m_cur.sticky || (m_cur.waits && !mem_ready)) begin
            // remain in the current step
        end else begin
            if (m_cur.fetch) build(opcode, funct);
            if (q_steps.size() > 0) m_cur = q_steps.pop_front();
            else                    m_cur = fetch_step();
            m_stepno++;
        end
    endtask

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] e);
        lit_t l;
        l.name = name; l.act = a; l.exp = e;
        lit_q.push_back(l);
    endtask

    task automatic assert_reset_now();
        rst_n = 1'b0;
        m_cur = fetch_step(); q_steps.delete(); m_stepno++;
    endtask

    // One clock: sample statistics at negedge, advance model at posedge
    task automatic tick();
        @(negedge clk);
        st_mrd   += int'(mem_read && i_or_d);
        st_memwb += int'(mem_to_reg && reg_write);
        st_rdwb  += int'(reg_dst && reg_write);
        st_rw    += int'(reg_write);
        st_hilo  += int'(hi_en && lo_en);
        st_ill   += int'(illegal_op);
        if (hi_en) st_mul_opsel = opsel;
        if (reg_dst && reg_write) st_lohi = alu_lo_hi;
        if (alu_src_a && alu_src_b == 2'b10 && !reg_write) begin
            st_it_opsel = opsel; st_it_signed = is_signed;
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fdelay, input int mdelay, input bit noise);
        int n, wcnt, last;
        bit left;
        opcode = op; funct = fn;
        st_mrd = 0; st_memwb = 0; st_rdwb = 0; st_rw = 0; st_hilo = 0; st_ill = 0;
        st_mul_opsel = '1; st_lohi = '1; st_it_opsel = '1; st_it_signed = 1'bx;
        n = 0; wcnt = 0; last = m_stepno; left = 0;
        do begin
            if (m_cur.waits) mem_ready = (wcnt >= (m_cur.fetch ? fdelay : mdelay));
            else             mem_ready = noise;
            tick();
            n++;
            if (m_stepno != last) begin wcnt = 0; last = m_stepno; end
            else wcnt++;
            if (!m_cur.fetch) left = 1;
        end while (!(left && (m_cur.fetch || m_cur.sticky)) && n < 60);
        if (n >= 60) lit($sformatf("bound_op%02h", op), 32'(n), 32'd0);
        st_cycles = n;
        mem_ready = 1'b0;
    endtask

    // Single compare process: literal expectations then model vs DUT per cycle
    initial begin
        lit_t l;
        ctl_t e;
        forever begin
            @(negedge clk);
            while (lit_q.size() > 0) begin
                l = lit_q.pop_front();
                checks++;
                if (l.act !== l.exp) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h", l.name, l.act, l.exp);
                end
            end
            if (!done) begin
                e = expected();
                checks++;
                if (dut_v !== e) begin
                    failures++;
                    $display("FAIL ctl_vector t=%0t op=%02h fn=%02h: got %07h expected %07h",
                             $time, opcode, funct, dut_v, e);
                end
            end
        end
    end

    logic [5:0] rfns [11] = '{6'h23, 6'h24, 6'h25, 6'h26, 6'h02, 6'h00,
                              6'h03, 6'h2A, 6'h2B, 6'h18, 6'h08};
    logic [5:0] iops [7]  = '{6'h09, 6'h10, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B};
    logic [5:0] jops [4]  = '{6'h04, 6'h05, 6'h02, 6'h03};

    initial begin
        int nz;
        m_cur = fetch_step();
        st_cycles = 0;

        // reset: everything quiet, even with an illegal opcode present
        opcode = 6'h3B; mem_ready = 1'b1;
        repeat (3) tick();
        lit("rst_mem_read", 32'(mem_read), 0);
        lit("rst_illegal", 32'(illegal_op), 0);
        mem_ready = 1'b0; opcode = 6'h00;
        rst_n = 1'b1;
        #1;
        lit("post_rst_mem_read", 32'(mem_read), 1);
        tick();

        // addu, plain then with slow fetch and stray mem_ready
        run_instr(6'h00, 6'h21, 0, 0, 0);
        lit("addu_cycles", 32'(st_cycles), 4);
        lit("addu_wb_cycles", 32'(st_rdwb), 1);
        run_instr(6'h00, 6'h21, 2, 0, 1);

        foreach (rfns[i]) run_instr(6'h00, rfns[i], i % 2, 0, i[0]);

        // lw with three wait cycles in MEM_READ
        run_instr(6'h23, 6'h00, 1, 3, 1);
        lit("lw_memread_cycles", 32'(st_mrd), 4);
        lit("lw_memwb_cycles", 32'(st_memwb), 1);
        run_instr(6'h2B, 6'h00, 0, 2, 1);

        run_instr(6'h00, 6'h19, 0, 0, 1);
        lit("multu_hilo_cycles", 32'(st_hilo), 1);
        lit("multu_opsel", 32'(st_mul_opsel), 3);
        lit("multu_reg_write", 32'(st_rw), 0);
        lit("multu_cycles", 32'(st_cycles), 3);

        run_instr(6'h00, 6'h10, 0, 0, 0);
        lit("mfhi_lo_hi", 32'(st_lohi), 2);
        run_instr(6'h00, 6'h12, 0, 0, 1);
        lit("mflo_lo_hi", 32'(st_lohi), 1);

        run_instr(6'h00, 6'h3F, 0, 0, 0);
        lit("bad_funct_illegal", 32'(st_ill), 1);

        foreach (iops[i]) run_instr(iops[i], 6'h21, 0, 0, i[0]);
        run_instr(6'h0C, 6'h00, 0, 0, 0);
        lit("andi_signed", 32'(st_it_signed), 0);
        lit("andi_opsel", 32'(st_it_opsel), 4);
        run_instr(6'h0A, 6'h00, 0, 0, 1);
        lit("slti_signed", 32'(st_it_signed), 1);
        lit("slti_opsel", 32'(st_it_opsel), 'h0A);

        foreach (jops[i]) run_instr(jops[i], 6'h00, i, 0, 1);

        run_instr(6'h3B, 6'h00, 0, 0, 1);
        lit("illegal_pulse", 32'(st_ill), 1);
        lit("illegal_cycles", 32'(st_cycles), 2);

        // reset asserted in the middle of a store wait
        opcode = 6'h2B; funct = 6'h00;
        nz = 0;
        while (!(m_cur.base.mem_write) && nz < 20) begin
            mem_ready = m_cur.fetch;
            tick();
            nz++;
        end
        mem_ready = 1'b0;
        tick();
        lit("sw_wait_mem_write", 32'(mem_write), 1);
        assert_reset_now();
        #1;
        lit("sw_abort_mem_write", 32'(mem_write), 0);
        lit("sw_abort_i_or_d", 32'(i_or_d), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        lit("sw_after_rst_mem_read", 32'(mem_read), 1);
        lit("sw_after_rst_i_or_d", 32'(i_or_d), 0);
        run_instr(6'h00, 6'h21, 0, 0, 0);

        // halt: outputs stay zero regardless of mem_ready
        run_instr(6'h3F, 6'h00, 0, 0, 1);
        nz = 0;
        for (int k = 0; k < 12; k++) begin
            mem_ready = k[0];
            opcode = (k < 6) ? 6'h00 : 6'h23;
            tick();
            if (dut_v != '0) nz++;
        end
        lit("halt_nonzero_cycles", 32'(nz), 0);

        // reset leaves halt and fetch resumes
        assert_reset_now();
        tick();
        rst_n = 1'b1;
        #1;
        lit("halt_exit_mem_read", 32'(mem_read), 1);
        run_instr(6'h09, 6'h00, 0, 0, 0);

        done = 1;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_ctrl.md
MIPS_CTRL -- requirements
Module: mips_ctrl

Interface
REQ-001 SHALL have parameter HALT_OPCODE, default 6'h3F, the opcode that enters HALT.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, jal, is_signed, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00=regB, 01=const 4, 10=ext imm, 11=ext imm<<2.
- pc_source  out  2  00=ALU result, 01=ALUOut reg, 10=jump target.
- alu_lo_hi  out  2  00=ALUOut, 01=LO, 10=HI.
- hi_en, lo_en  out  1 each  HI/LO load.
- opsel  out  5  ALU operation select.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode/funct.

Function
REQ-003 opsel codes SHALL be: ADD_U 00, SUB_U 01, MULT 02, MUL_U 03, AND 04, OR 05, XOR 06, SRL 07, SLL 08, SRA 09, SLT 0A, SLT_U 0B, BEQ 0C, BNE 0D, PASS_A 10 (hex).
REQ-004 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, RTYPE_EX, RTYPE_WB, ITYPE_EX, ITYPE_WB, BRANCH, JUMP, JAL, HALT; any unlisted control output is 0.
REQ-005 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, opsel=ADD_U, pc_source=00.
REQ-006 FETCH: ir_write=1 and pc_write=1 only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
REQ-007 DECODE: alu_src_a=0, alu_src_b=11, is_signed=1, opsel=ADD_U, for the branch target.
REQ-008 DECODE next state: opcode 00 goes to RTYPE_EX; 23/2B go to MEM_ADDR; 09,0A,0B,0C,0D,0E,10 go to ITYPE_EX; 04/05 go to BRANCH; 02 goes to JUMP; 03 goes to JAL; HALT_OPCODE goes to HALT.
REQ-009 DECODE with any other opcode SHALL pulse illegal_op and go to FETCH.
REQ-010 RTYPE_EX: alu_src_a=1, alu_src_b=00; funct maps to opsel: 21 ADD_U, 23 SUB_U, 18 MULT, 19 MUL_U, 24 AND, 25 OR, 26 XOR, 02 SRL, 00 SLL, 03 SRA, 2A SLT, 2B SLT_U.
REQ-011 RTYPE_EX with mult/multu: hi_en=lo_en=1, then go to FETCH.
REQ-012 RTYPE_EX with jr (funct 08): opsel=PASS_A, pc_write=1, pc_source=00, then go to FETCH.
REQ-013 RTYPE_EX with mfhi (10) or mflo (12): opsel=ADD_U, then go to RTYPE_WB.
REQ-014 RTYPE_EX with an unknown funct: pulse illegal_op, then go to FETCH.
REQ-015 RTYPE_EX with any other valid funct: go to RTYPE_WB.
REQ-016 RTYPE_WB: reg_dst=1, reg_write=1, opsel held at the RTYPE_EX value, alu_lo_hi=10 for mfhi, 01 for mflo, else 00; then go to FETCH.
REQ-017 ITYPE_EX: alu_src_a=1, alu_src_b=10; opsel 09 ADD_U, 10 SUB_U, 0C AND, 0D OR, 0E XOR, 0A SLT, 0B SLT_U.
REQ-018 ITYPE_EX: is_signed=1 for opcodes 09, 10, 0A, 0B and 0 for 0C, 0D, 0E; then go to ITYPE_WB.
REQ-019 ITYPE_WB: reg_dst=0, reg_write=1, ITYPE_EX opsel/is_signed held; then go to FETCH.
REQ-020 MEM_ADDR: alu_src_a=1, alu_src_b=10, is_signed=1, opsel=ADD_U; go to MEM_READ (lw) or MEM_WRITE (sw).
REQ-021 MEM_READ: i_or_d=1, mem_read=1; hold until mem_ready=1, then go to MEM_WB.
REQ-022 MEM_WB: mem_to_reg=1, reg_dst=0, reg_write=1; then go to FETCH.
REQ-023 MEM_WRITE: i_or_d=1, mem_write=1; hold until mem_ready=1, then go to FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, opsel=BEQ (04) or BNE (05), pc_write_cond=1, pc_source=01; then go to FETCH.
REQ-025 JUMP: pc_write=1, pc_source=10; then go to FETCH.
REQ-026 JAL: pc_write=1, pc_source=10, jal=1, reg_write=1; then go to FETCH.
REQ-027 HALT: all outputs 0; stay in HALT until reset.
REQ-028 Outputs SHALL be combinational from state, opcode, funct and mem_ready only; no output depends on unregistered internal paths beyond these.
REQ-029 mem_ready outside FETCH, MEM_READ and MEM_WRITE SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL force state FETCH asynchronously, including mid memory wait, aborting any access.
REQ-031 During reset, all outputs SHALL be 0 and illegal_op SHALL be suppressed.
REQ-032 In the first clk cycle after rst_n rises, mem_read=1 (FETCH).

Verification
REQ-033 addu: opcode 00, funct 21, mem_ready=1 in FETCH -> FETCH, DECODE, RTYPE_EX (opsel=00), RTYPE_WB (reg_dst=1, reg_write=1), FETCH; 4 cycles.
REQ-034 lw with mem_ready low for 3 cycles in MEM_READ -> mem_read=1, i_or_d=1 for 4 cycles; MEM_WB reg_write=1 and mem_to_reg=1 exactly once.
REQ-035 multu (funct 19) -> RTYPE_EX with opsel=03, hi_en=lo_en=1, reg_write=0, then FETCH; mfhi -> RTYPE_WB with alu_lo_hi=10.
REQ-036 andi (0C) -> is_signed=0, opsel=04; slti (0A) -> is_signed=1, opsel=0A.
REQ-037 opcode 3B -> illegal_op=1 for one cycle in DECODE, then FETCH; opcode 3F -> HALT, outputs 0 for 10+ cycles.
REQ-038 rst_n low mid MEM_WRITE -> mem_write drops to 0 immediately; after release, FETCH with mem_read=1.
